i2c_apb_top_level: RTL and testbench
====================================

# i2c_apb_top_level

APB-slave-controlled I2C master: a host programs prescale, slave address and command registers over APB, pushes write bytes into a TX FIFO, and the block drives the I2C bus (SCL/SDA) to perform the transfer. It is the top of the I2C-APB subsystem; SDA/SCL outputs go to external open-drain pads.

## Interface
- No parameters. TX and RX FIFO depth is fixed at 4 bytes each, 8 bits wide.
- PCLK  in  1  sole clock; all state is clocked on its rising edge.
- PRESETn  in  1  asynchronous, active-low reset.
- PSELx  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  8  register address; only PADDR[7:5] is decoded.
- PWDATA  in  8  write data.
- sda_in  in  1  SDA line as sampled from the pad.
- i2c_core_clk_top  in  1  slow bit-rate reference. It is a data input, not a clock: synchronised with 2 flops in PCLK and rising-edge detected. Its frequency must be ≤ PCLK/4.
- PREADY  out  1  tied to 1 (zero wait states).
- PRDATA  out  8  read data.
- sda_out  out  1  SDA drive; 1 = release (high), 0 = pull low.
- scl_out  out  1  SCL drive; 1 = release.

## Operation
- **APB write:** PSELx & PENABLE & PWRITE. **APB read:** PSELx & PENABLE & !PWRITE. One action per cycle in which the condition holds.
- **Register map (PADDR[7:5]):**
  - 001 PRESCALE: RW, 8 bits.
  - 010 ADDR: RW; [6:0] hold the 7-bit slave address, [7] reads 0.
  - 011 STATUS: RO.
  - 100 TXDATA: write pushes into the TX FIFO; reads return 0.
  - 101 RXDATA: read pops the RX FIFO; reads 0 when the FIFO is empty.
  - 110 CMD: RW.
  - 000 and 111: reads 0, writes ignored.
- **PRDATA:** combinational mux of the selected register during a read; 0 otherwise.
- **CMD bits:**
  - [7] enable.
  - [6] start, self-clearing.
  - [5] direction (0 = write, 1 = read).
  - [3:0] read byte count (0 is treated as 1).
  - [4] reserved, reads 0.
- **STATUS bits:**
  - [0] busy.
  - [1] TX full.
  - [2] TX empty.
  - [3] RX full.
  - [4] RX empty.
  - [5] NACK (sticky).
  - [7:6] 0.
- **FIFO boundary rules:**
  - A push to a full TX FIFO is dropped.
  - A pop from an empty RX FIFO returns 0 and leaves the FIFO unchanged.
  - A received byte arriving with the RX FIFO full is dropped.
  - Simultaneous push and pop in the same cycle are both honoured.
- **Quarter tick:** one pulse every P synchronised rising edges of i2c_core_clk_top, where P = PRESCALE and P = 0 is treated as 1.
- **FSM states:** IDLE, START, ADDR, ADDR_ACK, WR, WR_ACK, RD, RD_ACK, STOP. The FSM advances only on quarter ticks.
- **Transitions:**
  - IDLE→START when CMD[7] and CMD[6] are both set. On this transition, clear CMD[6] and STATUS[5].
  - START→ADDR.
  - ADDR sends {ADDR[6:0], CMD[5]} MSB first.
  - ADDR_ACK: if sda_in=1, set NACK and go to STOP. If ACK and write, go to WR if TX is non-empty, else STOP. If ACK and read, go to RD.
  - WR pops one byte and sends it MSB first. WR_ACK: on NACK set the flag and go to STOP; else go to WR if TX is non-empty, else STOP.
  - RD shifts 8 bits into the RX FIFO. RD_ACK: master drives ACK (0) if more bytes remain, else NACK (1) then STOP.
  - STOP→IDLE.
- A start command written while busy is ignored (CMD[6] is cleared).

## Timing
- **Reset values:**
  - PRDATA=0, PREADY=1, sda_out=1, scl_out=1.
  - All registers 0.
  - FIFOs empty, so STATUS = 0x14.
  - FSM in IDLE.
- Reset asserted mid-transfer releases both bus lines immediately, asynchronously.
- **Data bit (4 quarters):**
  - q0: SCL low, set SDA.
  - q1: SCL high.
  - q2: SCL high, sample sda_in.
  - q3: SCL low.
- **START:** SDA=1/SCL=1 for one quarter, then SDA=0 for one quarter, then SCL=0.
- **STOP:** SDA=0/SCL=0, then SCL=1, then SDA=1, each one quarter.
- SDA changes only while SCL is low, except in START and STOP.
- busy is high from the IDLE→START transition until STOP completes.
- Register writes take effect on the PCLK edge that ends the access phase.
- A TX push during WR is visible to the next WR_ACK decision.

## Test plan
- **Reset:** PRESETn low → PRDATA=0, sda_out=1, scl_out=1. After release, reading 0x60 returns 0x14.
- **Readback:** write 0x20←0x04 and 0x4F←0x01 → reading 0x20 returns 0x04 and reading 0x40 returns 0x01. PREADY=1 throughout.
- **Write with ACK:** PRESCALE=4, ADDR=1, TX←0x01, CMD←0xC0, sda_in held 0.
  - Bus shows START, then 0x02, ACK, 0x01, ACK, STOP.
  - Each bit lasts 16 i2c_core_clk_top periods.
  - CMD reads 0x80 after start; STATUS returns to 0x14.
- **NACK:** same setup with sda_in held 1 → STOP right after the 9th address clock. STATUS[5]=1, TX still holds 0x01.
- **FIFO full:** while idle, push 0x01–0x05 → STATUS[1]=1. A later transfer with ACK sends only 0x01–0x04.
- **Read:** ADDR=1, CMD←0xE2 with slave driving 0xA5, 0x3C → bus address byte 0x03; master ACKs the first byte and NACKs the second. Two RXDATA reads return 0xA5 then 0x3C.

Source files
------------

// File: rtl/i2c_apb_top_level.sv
// APB-programmed I2C master: PRESCALE/ADDR/CMD registers, 4-deep TX and RX
// byte FIFOs, and a quarter-tick-paced bus FSM driving open-drain SCL/SDA.
module i2c_apb_top_level (
   input  logic       PCLK,
   input  logic       PRESETn,
   input  logic       PSELx,
   input  logic       PENABLE,
   input  logic       PWRITE,
   input  logic [7:0] PADDR,
   input  logic [7:0] PWDATA,
   input  logic       sda_in,
   input  logic       i2c_core_clk_top,
   output logic       PREADY,
   output logic [7:0] PRDATA,
   output logic       sda_out,
   output logic       scl_out
);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WR, S_WR_ACK, S_RD, S_RD_ACK, S_STOP
   } state_t;

   localparam logic [2:0] REG_PRESCALE = 3'b001;
   localparam logic [2:0] REG_ADDR     = 3'b010;
   localparam logic [2:0] REG_STATUS   = 3'b011;
   localparam logic [2:0] REG_TXDATA   = 3'b100;
   localparam logic [2:0] REG_RXDATA   = 3'b101;
   localparam logic [2:0] REG_CMD      = 3'b110;

   logic       apb_wr, apb_rd;
   logic [2:0] sel;
   logic [7:0] prescale;
   logic [6:0] slave_addr;
   logic       cmd_en, cmd_start, cmd_dir;
   logic [3:0] cmd_cnt;
   logic       nack, busy;
   state_t     state;

   logic [7:0] tx_mem [4];
   logic [1:0] tx_wp, tx_rp;
   logic [2:0] tx_cnt;
   logic       tx_full, tx_empty, tx_push, tx_pop;
   logic [7:0] rx_mem [4];
   logic [1:0] rx_wp, rx_rp;
   logic [2:0] rx_cnt;
   logic       rx_full, rx_empty, rx_push, rx_pop;

   logic [2:0] core_sync;
   logic       core_rise, qtick;
   logic [7:0] presc_cnt, presc_eff;

   logic [1:0] q;
   logic [2:0] bit_cnt;
   logic [7:0] shreg;
   logic       samp;
   logic [3:0] rd_left;
   logic       start_go;

   assign PREADY   = 1'b1;
   assign apb_wr   = PSELx & PENABLE & PWRITE;
   assign apb_rd   = PSELx & PENABLE & ~PWRITE;
   assign sel      = PADDR[7:5];
   assign busy     = (state != S_IDLE);
   assign tx_full  = (tx_cnt == 3'd4);
   assign tx_empty = (tx_cnt == 3'd0);
   assign rx_full  = (rx_cnt == 3'd4);
   assign rx_empty = (rx_cnt == 3'd0);

   assign start_go = qtick && (state == S_IDLE) && cmd_en && cmd_start;
   assign tx_push  = apb_wr && (sel == REG_TXDATA) && !tx_full;
   assign tx_pop   = qtick && (q == 2'd3) && !samp && !tx_empty &&
                     (((state == S_ADDR_ACK) && !cmd_dir) || (state == S_WR_ACK));
   assign rx_push  = qtick && (state == S_RD) && (q == 2'd3) && (bit_cnt == 3'd0) && !rx_full;
   assign rx_pop   = apb_rd && (sel == REG_RXDATA) && !rx_empty;

   // Host-visible control registers; the FSM clears the start bit when it launches.
   // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         prescale   <= '0;
         slave_addr <= '0;
         cmd_en     <= 1'b0;
         cmd_start  <= 1'b0;
         cmd_dir    <= 1'b0;
         cmd_cnt    <= '0;
      end else begin
         if (start_go) cmd_start <= 1'b0;
         if (apb_wr) begin
            case (sel)
               REG_PRESCALE: prescale   <= PWDATA;
               REG_ADDR:     slave_addr <= PWDATA[6:0];
               REG_CMD: begin
                  cmd_en    <= PWDATA[7];
                  cmd_start <= PWDATA[6] & ~busy;
                  cmd_dir   <= PWDATA[5];
                  cmd_cnt   <= PWDATA[3:0];
               end
               default: ;
            endcase
         end
      end
   end

   // FIFO storage arrays; contents are only meaningful between the pointers.
   // NOTE: the memories carry no reset -- the pointer/count reset makes them empty.
   always_ff @(posedge PCLK) begin
      if (tx_push) tx_mem[tx_wp] <= PWDATA;
      if (rx_push) rx_mem[rx_wp] <= shreg;
   end

   // FIFO pointers and occupancy; push and pop in one cycle both take effect.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         tx_wp  <= '0;
         tx_rp  <= '0;
         tx_cnt <= '0;
         rx_wp  <= '0;
         rx_rp  <= '0;
         rx_cnt <= '0;
      end else begin
         if (tx_push) tx_wp <= tx_wp + 2'd1;
         if (tx_pop)  tx_rp <= tx_rp + 2'd1;
         tx_cnt <= tx_cnt + {2'b00, tx_push} - {2'b00, tx_pop};
         if (rx_push) rx_wp <= rx_wp + 2'd1;
         if (rx_pop)  rx_rp <= rx_rp + 2'd1;
         rx_cnt <= rx_cnt + {2'b00, rx_push} - {2'b00, rx_pop};
      end
   end

   // Bit-rate reference: two-flop synchroniser plus one flop for rising-edge detection.
   assign core_rise = core_sync[1] & ~core_sync[2];
   assign presc_eff = (prescale == 8'd0) ? 8'd1 : prescale;
   assign qtick     = core_rise && (presc_cnt >= presc_eff - 8'd1);

   // Quarter-tick divider: counts synchronised reference edges up to PRESCALE.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         core_sync <= '0;
         presc_cnt <= '0;
      end else begin
         core_sync <= {core_sync[1:0], i2c_core_clk_top};
         if (qtick)          presc_cnt <= '0;
         else if (core_rise) presc_cnt <= presc_cnt + 8'd1;
      end
   end

   // Bus sequencer: each quarter tick applies one quarter of SCL/SDA waveform.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state   <= S_IDLE;
         q       <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         samp    <= 1'b0;
         rd_left <= '0;
         nack    <= 1'b0;
         sda_out <= 1'b1;
         scl_out <= 1'b1;
      end else if (qtick) begin
         q <= q + 2'd1;
         case (state)
            S_IDLE: begin
               q       <= '0;
               sda_out <= 1'b1;
               scl_out <= 1'b1;
               if (cmd_en && cmd_start) begin
                  state <= S_START;
                  nack  <= 1'b0;
               end
            end
            S_START: begin
               case (q)
                  2'd0:    begin sda_out <= 1'b1; scl_out <= 1'b1; end
                  2'd1:    sda_out <= 1'b0;
                  default: begin
                     scl_out <= 1'b0;
                     q       <= '0;
                     state   <= S_ADDR;
                     shreg   <= {slave_addr, cmd_dir};
                     bit_cnt <= 3'd7;
                  end
               endcase
            end
            S_ADDR, S_WR: begin
               case (q)
                  2'd0:    begin scl_out <= 1'b0; sda_out <= shreg[7]; end
                  2'd1,
                  2'd2:    scl_out <= 1'b1;
                  default: begin
                     scl_out <= 1'b0;
                     if (bit_cnt == 3'd0) begin
                        state <= (state == S_ADDR) ? S_ADDR_ACK : S_WR_ACK;
                     end else begin
                        bit_cnt <= bit_cnt - 3'd1;
                        shreg   <= {shreg[6:0], 1'b0};
                     end
                  end
               endcase
            end
            S_ADDR_ACK, S_WR_ACK: begin
               case (q)
                  2'd0:    begin scl_out <= 1'b0; sda_out <= 1'b1; end
                  2'd1:    scl_out <= 1'b1;
                  2'd2:    begin scl_out <= 1'b1; samp <= sda_in; end
                  default: begin
                     scl_out <= 1'b0;
                     if (samp) begin
                        nack  <= 1'b1;
                        state <= S_STOP;
                     end else if ((state == S_ADDR_ACK) && cmd_dir) begin
                        state   <= S_RD;
                        bit_cnt <= 3'd7;
                        rd_left <= (cmd_cnt == 4'd0) ? 4'd1 : cmd_cnt;
                     end else if (!tx_empty) begin
                        state   <= S_WR;
                        shreg   <= tx_mem[tx_rp];
                        bit_cnt <= 3'd7;
                     end else begin
                        state <= S_STOP;
                     end
                  end
               endcase
            end
            S_RD: begin
               case (q)
                  2'd0:    begin scl_out <= 1'b0; sda_out <= 1'b1; end
                  2'd1:    scl_out <= 1'b1;
                  2'd2:    begin scl_out <= 1'b1; shreg <= {shreg[6:0], sda_in}; end
                  default: begin
                     scl_out <= 1'b0;
                     if (bit_cnt == 3'd0) begin
                        state   <= S_RD_ACK;
                        rd_left <= rd_left - 4'd1;
                     end else begin
                        bit_cnt <= bit_cnt - 3'd1;
                     end
                  end
               endcase
            end
            S_RD_ACK: begin
               case (q)
                  2'd0:    begin scl_out <= 1'b0; sda_out <= (rd_left == 4'd0); end
                  2'd1,
                  2'd2:    scl_out <= 1'b1;
                  default: begin
                     scl_out <= 1'b0;
                     if (rd_left == 4'd0) begin
                        state <= S_STOP;
                     end else begin
                        state   <= S_RD;
                        bit_cnt <= 3'd7;
                     end
                  end
               endcase
            end
            S_STOP: begin
               case (q)
                  2'd0:    begin sda_out <= 1'b0; scl_out <= 1'b0; end
                  2'd1:    scl_out <= 1'b1;
                  default: begin
                     sda_out <= 1'b1;
                     q       <= '0;
                     state   <= S_IDLE;
                  end
               endcase
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Read-data mux, driven only while an APB read access phase is active.
   // NOTE: PRDATA gets a default first so no path through the mux infers a latch.
   always_comb begin
      PRDATA = 8'h00;
      if (apb_rd) begin
         case (sel)
            REG_PRESCALE: PRDATA = prescale;
            REG_ADDR:     PRDATA = {1'b0, slave_addr};
            REG_STATUS:   PRDATA = {2'b00, nack, rx_empty, rx_full, tx_empty, tx_full, busy};
            REG_RXDATA:   PRDATA = rx_empty ? 8'h00 : rx_mem[rx_rp];
            REG_CMD:      PRDATA = {cmd_en, cmd_start, cmd_dir, 1'b0, cmd_cnt};
            default:      PRDATA = 8'h00;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_apb_top_level.sv
// Scoreboard bench for i2c_apb_top_level: APB reads and decoded I2C bus tokens
// are checked by monitors against queues filled by the directed stimulus.
`timescale 1ns/1ps
module tb_i2c_apb_top_level;

   localparam int TOK_START = 512;
   localparam int TOK_STOP  = 513;
   localparam int BIT_NS    = 1280;   // 4 quarters x PRESCALE 4 x 80 ns reference period

   logic       PCLK = 1'b0;
   logic       PRESETn = 1'b0;
   logic       PSELx = 1'b0;
   logic       PENABLE = 1'b0;
   logic       PWRITE = 1'b0;
   logic [7:0] PADDR = 8'h00;
   logic [7:0] PWDATA = 8'h00;
   logic       sda_in = 1'b1;
   logic       core_clk = 1'b0;
   logic       PREADY;
   logic [7:0] PRDATA;
   logic       sda_out;
   logic       scl_out;

   int    checks = 0;
   int    errors = 0;
   int    exp_rd[$];
   string exp_rd_name[$];
   int    exp_bus[$];

   i2c_apb_top_level dut (
      .PCLK             (PCLK),
      .PRESETn          (PRESETn),
      .PSELx            (PSELx),
      .PENABLE          (PENABLE),
      .PWRITE           (PWRITE),
      .PADDR            (PADDR),
      .PWDATA           (PWDATA),
      .sda_in           (sda_in),
      .i2c_core_clk_top (core_clk),
      .PREADY           (PREADY),
      .PRDATA           (PRDATA),
      .sda_out          (sda_out),
      .scl_out          (scl_out)
   );

   always #5  PCLK = ~PCLK;
   always #40 core_clk = ~core_clk;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic apb_write(input logic [7:0] addr, input logic [7:0] data);
      @(posedge PCLK); #1;
      PSELx = 1'b1; PWRITE = 1'b1; PADDR = addr; PWDATA = data; PENABLE = 1'b0;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(posedge PCLK); #1;
      PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [7:0] addr, input int expected, input string name);
      exp_rd.push_back(expected);
      exp_rd_name.push_back(name);
      @(posedge PCLK); #1;
      PSELx = 1'b1; PWRITE = 1'b0; PADDR = addr; PENABLE = 1'b0;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(posedge PCLK); #1;
      PSELx = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic wait_bus(input int budget);
      int n = 0;
      while (exp_bus.size() != 0 && n < budget) begin
         @(posedge PCLK);
         n++;
      end
      checks++;
      if (exp_bus.size() != 0) begin
         errors++;
         $display("FAIL bus_timeout: %0d tokens pending, expected 0", exp_bus.size());
      end
      repeat (200) @(posedge PCLK);
   endtask

   task automatic bus_token(input int tok);
      if (exp_bus.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL bus_unexpected: got token 0x%0h, expected none", tok);
      end else begin
         check("bus_token", tok, exp_bus.pop_front());
      end
   endtask

   // Slave model for the read transfer: ACKs the address, then returns 0xA5, 0x3C.
   task automatic slave_read();
      logic [26:0] bits;
      bits = {8'hFF, 1'b0, 8'hA5, 1'b1, 8'h3C, 1'b1};
      sda_in = 1'b1;
      do @(negedge sda_out); while (!scl_out);
      for (int i = 0; i < 27; i++) begin
         @(negedge scl_out);
         sda_in = bits[26 - i];
      end
   endtask

   // APB read monitor: compares PRDATA during every read access phase.
   always @(negedge PCLK) begin
      if (PRESETn && PSELx && PENABLE && !PWRITE) begin
         if (exp_rd.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_unexpected: got 0x%0h, expected none", PRDATA);
         end else begin
            check(exp_rd_name.pop_front(), {24'h0, PRDATA}, exp_rd.pop_front());
            check("pready", {31'h0, PREADY}, 32'd1);
         end
      end
   end

   // Bus monitor: decodes START/STOP and 9-bit (byte + ack slot) tokens from the master drive.
   logic       prev_sda = 1'b1;
   logic       prev_scl = 1'b1;
   int         bitcnt = 0;
   logic [8:0] sr = '0;
   time        last_rise = 0;
   always @(sda_out or scl_out) begin
      if (!PRESETn) begin
         bitcnt = 0;
      end else if (scl_out && prev_scl && prev_sda && !sda_out) begin
         bitcnt = 0;
         bus_token(TOK_START);
      end else if (scl_out && prev_scl && !prev_sda && sda_out) begin
         bitcnt = 0;
         bus_token(TOK_STOP);
      end else if (scl_out && !prev_scl) begin
         if (bitcnt > 0) check("bit_period_ns", 32'($time - last_rise), BIT_NS);
         last_rise = $time;
         sr = {sr[7:0], sda_out};
         bitcnt++;
         if (bitcnt == 9) begin
            bus_token({23'h0, sr});
            bitcnt = 0;
         end
      end
      prev_sda = sda_out;
      prev_scl = scl_out;
   end

   initial begin
      #900us;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      // Reset state
      #22;
      check("rst_prdata", {24'h0, PRDATA}, 32'h0);
      check("rst_sda", {31'h0, sda_out}, 32'd1);
      check("rst_scl", {31'h0, scl_out}, 32'd1);
      check("rst_pready", {31'h0, PREADY}, 32'd1);
      @(posedge PCLK); #1;
      PRESETn = 1'b1;
      apb_read(8'h60, 8'h14, "status_reset");
      apb_read(8'hC0, 8'h00, "cmd_reset");
      apb_read(8'h20, 8'h00, "prescale_reset");

      // Register readback and decode
      apb_write(8'h20, 8'h04);
      apb_write(8'h4F, 8'h01);
      apb_read(8'h20, 8'h04, "prescale_rb");
      apb_read(8'h40, 8'h01, "addr_rb");
      apb_write(8'h40, 8'h81);
      apb_read(8'h40, 8'h01, "addr_bit7_zero");
      apb_write(8'hE0, 8'hFF);
      apb_read(8'hE0, 8'h00, "reg111_read");
      apb_read(8'h00, 8'h00, "reg000_read");
      apb_read(8'h80, 8'h00, "txdata_read");
      apb_read(8'hA0, 8'h00, "rx_empty_pop");

      // Write with ACK: START, 0x02+ack, 0x01+ack, STOP
      sda_in = 1'b0;
      apb_write(8'h80, 8'h01);
      apb_read(8'h60, 8'h10, "status_tx_loaded");
      exp_bus.push_back(TOK_START);
      exp_bus.push_back({8'h02, 1'b1});
      exp_bus.push_back({8'h01, 1'b1});
      exp_bus.push_back(TOK_STOP);
      apb_write(8'hC0, 8'hC0);
      wait_bus(20000);
      apb_read(8'hC0, 8'h80, "cmd_after_start");
      apb_read(8'h60, 8'h14, "status_after_write");

      // Address NACK: STOP right after the address byte, TX keeps 0x01
      sda_in = 1'b1;
      apb_write(8'h80, 8'h01);
      exp_bus.push_back(TOK_START);
      exp_bus.push_back({8'h02, 1'b1});
      exp_bus.push_back(TOK_STOP);
      apb_write(8'hC0, 8'hC0);
      wait_bus(20000);
      apb_read(8'h60, 8'h30, "status_nack");

      // TX FIFO full: 0x01 held over, push 0x02..0x05, 0x05 dropped
      apb_write(8'h80, 8'h02);
      apb_write(8'h80, 8'h03);
      apb_write(8'h80, 8'h04);
      apb_read(8'h60, 8'h32, "status_tx_full");
      apb_write(8'h80, 8'h05);
      apb_read(8'h60, 8'h32, "status_push_dropped");
      sda_in = 1'b0;
      exp_bus.push_back(TOK_START);
      exp_bus.push_back({8'h02, 1'b1});
      exp_bus.push_back({8'h01, 1'b1});
      exp_bus.push_back({8'h02, 1'b1});
      exp_bus.push_back({8'h03, 1'b1});
      exp_bus.push_back({8'h04, 1'b1});
      exp_bus.push_back(TOK_STOP);
      apb_write(8'hC0, 8'hC0);
      repeat (1000) @(posedge PCLK);
      apb_write(8'hC0, 8'hC0);
      apb_read(8'hC0, 8'h80, "cmd_start_ignored_busy");
      wait_bus(20000);
      apb_read(8'h60, 8'h14, "status_after_fifo");

      // Read two bytes: address 0x03, data ACKed then NACKed
      exp_bus.push_back(TOK_START);
      exp_bus.push_back({8'h03, 1'b1});
      exp_bus.push_back({8'hFF, 1'b0});
      exp_bus.push_back({8'hFF, 1'b1});
      exp_bus.push_back(TOK_STOP);
      fork
         slave_read();
      join_none
      apb_write(8'hC0, 8'hE2);
      wait_bus(20000);
      apb_read(8'hC0, 8'hA2, "cmd_after_read");
      apb_read(8'h60, 8'h04, "status_rx_loaded");
      apb_read(8'hA0, 8'hA5, "rx_byte0");
      apb_read(8'hA0, 8'h3C, "rx_byte1");
      apb_read(8'hA0, 8'h00, "rx_empty_after");
      apb_read(8'h60, 8'h14, "status_final");

      repeat (10) @(posedge PCLK);
      check("rd_queue_drained", exp_rd.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
